plic_vec: RTL

//  Parametrised external-interrupt controller: NUM_SRC sources, per-source enable, fixed priority, vectored entry.
//  On accept it stalls the pipeline and writes mepc, mstatus (MIE cleared) and mcause to csr_reg, one CSR per cycle.
//  It then pulses int_assert_o with int_addr_o = BASE_ADDR + 4*id to pipe_ctrl.
//  A source stays in service until mret_i; no nesting.

---
 rtl/plic_vec_pkg.sv | 22 ++
 rtl/plic_prio_enc.sv | 24 ++
 rtl/plic_vec.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/plic_vec_pkg.sv
// Shared constants and state encoding for the vectored external-interrupt controller.
// CSR addresses, the vector table base and the one-hot state codes live here.
package plic_vec_pkg;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [31:0] PLIC_ADDR_BASE = 32'h0000_0800;

    typedef enum logic [4:0] {
        PLIC_S_IDLE    = 5'b00001,
        PLIC_S_MEPC    = 5'b00010,
        PLIC_S_MSTATUS = 5'b00100,
        PLIC_S_MCAUSE  = 5'b01000,
        PLIC_S_ASSERT  = 5'b10000
    } plic_state_e;

    function automatic logic [31:0] csr_addr(input logic [11:0] a);
        return {20'h0, a};
    endfunction

endpackage

// File: rtl/plic_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of the request vector.
// Index 0 has the highest priority; valid_o is low when no request is set.
module plic_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic [ID_W-1:0]    id_o,
    output logic               valid_o
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_vec.sv
// Vectored external-interrupt controller: on accept it writes mepc, mstatus and mcause,
// then pulses int_assert_o with the vector address. Define PLIC_EDGE_TRIG_EN for edge-triggered sources.
module plic_vec
    import plic_vec_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter int          ID_W       = 3,
    parameter logic [31:0] BASE_ADDR  = PLIC_ADDR_BASE,
    parameter logic [31:0] MCAUSE_VAL = 32'h8000_000B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [NUM_SRC-1:0] src_en_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               inst_addr_valid_i,
    input  logic               mret_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic               csr_we_o,
    output logic [31:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               stall_flag_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [ID_W-1:0]    int_id_o,
    output logic               in_service_o,
    output logic [4:0]         dbg_state_o
);

    plic_state_e        state_q, state_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    logic               accept;
    logic               in_service_q;
    logic [ID_W-1:0]    id_q;
    logic [31:0]        addr_q;

`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] clr;

    assign clr = accept ? (NUM_SRC'(1) << win_id) : '0;

    // A new edge in the same cycle as the claim of that source must survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= (pending_q & ~clr) | (irq_i & ~irq_prev_q);
        end
    end

    assign pending = pending_q;
`else
    assign pending = irq_i;
`endif

    assign req = pending & src_en_i;

    plic_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req_i   (req),
        .id_o    (win_id),
        .valid_o (win_valid)
    );

    // Gated by rst_n so a held request cannot raise stall while in reset.
    assign accept = rst_n && (state_q == PLIC_S_IDLE) && win_valid && csr_mstatus_i[3]
                    && inst_addr_valid_i && !in_service_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLIC_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLIC_S_IDLE:    if (accept) state_d = PLIC_S_MEPC;
            PLIC_S_MEPC:    state_d = PLIC_S_MSTATUS;
            PLIC_S_MSTATUS: state_d = PLIC_S_MCAUSE;
            PLIC_S_MCAUSE:  state_d = PLIC_S_ASSERT;
            PLIC_S_ASSERT:  state_d = PLIC_S_IDLE;
            default:        state_d = PLIC_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_service_q <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
        end else if (accept) begin
            in_service_q <= 1'b1;
            id_q         <= win_id;
            addr_q       <= inst_addr_i;
        end else if (mret_i && in_service_q) begin
            in_service_q <= 1'b0;
            id_q         <= '0;
        end
    end

    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            PLIC_S_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = csr_addr(CSR_MEPC);
                csr_wdata_o = addr_q;
            end
            PLIC_S_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = csr_addr(CSR_MSTATUS);
                csr_wdata_o = {csr_mstatus_i[31:4], 1'b0, csr_mstatus_i[2:0]};
            end
            PLIC_S_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = csr_addr(CSR_MCAUSE);
                csr_wdata_o = MCAUSE_VAL;
            end
            PLIC_S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = BASE_ADDR + 32'({id_q, 2'b00});
            end
            default: ;
        endcase
    end

    assign stall_flag_o = accept || (state_q != PLIC_S_IDLE);
    assign int_id_o     = in_service_q ? id_q : '0;
    assign in_service_o = in_service_q;
    assign dbg_state_o  = state_q;

endmodule
